// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the unified-memory arbiter.
// Optional starvation guard is enabled with `define MEM_ARB_STARVE_EN.
package mem_arbiter_pkg;

    localparam int W_RESP = 2;

    typedef enum logic [W_RESP-1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_DATA = 2'd2
    } resp_e;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational grant picker: data wins, IF gets a forced turn after STARVE_MAX
// consecutive denials when `define MEM_ARB_STARVE_EN is set.
module mem_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
`ifdef MEM_ARB_STARVE_EN
    input  logic  clk,
`endif
    input  logic  rst,
    input  logic  if_req_i,
    input  logic  d_req_i,
    output resp_e gnt_o
);

    logic force_if;

`ifdef MEM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign force_if = (cnt_q == CNT_W'(STARVE_MAX));

    // Counts consecutive cycles in which IF wanted the memory and lost.
    always_comb begin
        cnt_d = '0;
        if (if_req_i && (gnt_o != RESP_IF)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        gnt_o = RESP_NONE;
        if (!rst) begin
            gnt_o = RESP_NONE;
        end else if (if_req_i && force_if) begin
            gnt_o = RESP_IF;
        end else if (d_req_i) begin
            gnt_o = RESP_DATA;
        end else if (if_req_i) begin
            gnt_o = RESP_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one memory macro between IF and EX.
// Build option: `define MEM_ARB_STARVE_EN adds the IF starvation guard.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_stall_o,
    output logic              if_v_o,
    output logic [WORD_W-1:0] if_data_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [WORD_W-1:0] d_wdata_i,
    output logic              d_stall_o,
    output logic              d_v_o,
    output logic [WORD_W-1:0] d_rdata_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_w_o,
    output logic [WORD_W-1:0] mem_d_o,
    input  logic [WORD_W-1:0] mem_q_i
);

    // Handshake: a request is accepted in any cycle where req_i=1 and stall_o=0;
    // a stalled requester holds req/addr/we/wdata until accepted or may withdraw.
    // The accepted access completes with v_o=1 exactly one cycle later.

    resp_e             gnt;
    resp_e             resp_q;
    resp_e             resp_d;
    logic [ADDR_W-1:0] mem_a_q;
    logic [ADDR_W-1:0] mem_a_d;

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
`ifdef MEM_ARB_STARVE_EN
        .clk      (clk),
`endif
        .rst      (rst),
        .if_req_i (if_req_i),
        .d_req_i  (d_req_i),
        .gnt_o    (gnt)
    );

    always_comb begin
        mem_a_d = mem_a_q;
        mem_w_o = 1'b0;
        mem_d_o = '0;
        resp_d  = gnt;
        case (gnt)
            RESP_DATA: begin
                mem_a_d = d_addr_i;
                mem_w_o = d_we_i;
                mem_d_o = d_wdata_i;
            end
            RESP_IF: begin
                mem_a_d = if_addr_i;
            end
            default: begin
                mem_a_d = mem_a_q;
            end
        endcase
    end

    assign mem_a_o = mem_a_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_q  <= RESP_NONE;
            mem_a_q <= '0;
        end else begin
            resp_q  <= resp_d;
            mem_a_q <= mem_a_d;
        end
    end

    assign if_stall_o = !rst || (if_req_i && (gnt != RESP_IF));
    assign d_stall_o  = !rst || (d_req_i && (gnt != RESP_DATA));

    // A flush only squashes the fetch word returning this cycle.
    assign if_v_o = rst && (resp_q == RESP_IF) && !if_flush_i;
    assign d_v_o  = rst && (resp_q == RESP_DATA);

    assign if_data_o = mem_q_i;
    assign d_rdata_o = mem_q_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model with its own memory image.
module tb_mem_arbiter;

    localparam int ADDR_W     = 16;
    localparam int WORD_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic              if_flush_i = 1'b0;
    logic              if_stall_o;
    logic              if_v_o;
    logic [WORD_W-1:0] if_data_o;
    logic              d_req_i = 1'b0;
    logic              d_we_i = 1'b0;
    logic [ADDR_W-1:0] d_addr_i = '0;
    logic [WORD_W-1:0] d_wdata_i = '0;
    logic              d_stall_o;
    logic              d_v_o;
    logic [WORD_W-1:0] d_rdata_o;
    logic [ADDR_W-1:0] mem_a_o;
    logic              mem_w_o;
    logic [WORD_W-1:0] mem_d_o;
    logic [WORD_W-1:0] mem_q_i = '0;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_stall_o(if_stall_o), .if_v_o(if_v_o), .if_data_o(if_data_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_stall_o(d_stall_o), .d_v_o(d_v_o), .d_rdata_o(d_rdata_o),
        .mem_a_o(mem_a_o), .mem_w_o(mem_w_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q_i)
    );

    always #5 clk = ~clk;

    // Memory macro: registered read, write lands before the next cycle's read.
    logic [WORD_W-1:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_w_o) mem[mem_a_o] <= mem_d_o;
        mem_q_i <= mem_w_o ? mem_d_o : mem[mem_a_o];
    end

    // Reference model state: its own memory image and the pending response.
    logic [WORD_W-1:0] ref_mem [0:65535];
    int                m_resp = 0;          // 0 none, 1 fetch, 2 data
    logic              m_resp_load = 1'b0;  // pending data response carries load data
    logic [WORD_W-1:0] m_exp = '0;
    logic [ADDR_W-1:0] m_last_a = '0;
    logic              m_if_held = 1'b0;
    logic              m_d_held = 1'b0;
    logic              rst_at_edge = 1'b0;
`ifdef MEM_ARB_STARVE_EN
    int                m_cnt = 0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict, check at negedge, advance the model at posedge.
    task automatic cycle();
        int                g;
        logic              e_if_stall;
        logic              e_d_stall;
        logic              e_w;
        logic [ADDR_W-1:0] e_a;
        g = 0;
        if (rst) begin
`ifdef MEM_ARB_STARVE_EN
            if (if_req_i && d_req_i && m_cnt == STARVE_MAX) g = 1;
            else
`endif
            if (d_req_i) g = 2;
            else if (if_req_i) g = 1;
        end
        e_if_stall = !rst || (if_req_i && g != 1);
        e_d_stall  = !rst || (d_req_i && g != 2);
        e_w        = (g == 2) && d_we_i;
        e_a        = (g == 2) ? d_addr_i : (g == 1) ? if_addr_i : m_last_a;

        @(negedge clk);
        chk("if_stall", if_stall_o, e_if_stall);
        chk("d_stall", d_stall_o, e_d_stall);
        chk("mem_w", mem_w_o, e_w);
        chk("mem_a", mem_a_o, e_a);
        chk("if_v", if_v_o, rst && m_resp == 1 && !if_flush_i);
        chk("d_v", d_v_o, rst && m_resp == 2);
        if (rst && m_resp == 1 && !if_flush_i) chk("if_data", if_data_o, m_exp);
        if (rst && m_resp == 2 && m_resp_load) chk("d_rdata", d_rdata_o, m_exp);
        if (e_w) chk("mem_d", mem_d_o, d_wdata_i);
        if (rst_at_edge) begin
            #2 rst = 1'b0;
            rst_at_edge = 1'b0;
        end

        @(posedge clk);
        m_if_held = rst && if_req_i && e_if_stall;
        m_d_held  = rst && d_req_i && e_d_stall;
        if (!rst) begin
            m_resp = 0;
            m_resp_load = 1'b0;
            m_last_a = '0;
`ifdef MEM_ARB_STARVE_EN
            m_cnt = 0;
`endif
        end else begin
            m_resp = g;
            m_resp_load = 1'b0;
            if (g == 2 && d_we_i) begin
                ref_mem[d_addr_i] = d_wdata_i;
            end else if (g != 0) begin
                m_exp = ref_mem[e_a];
                m_resp_load = (g == 2);
            end
            m_last_a = e_a;
`ifdef MEM_ARB_STARVE_EN
            m_cnt = (if_req_i && g != 1) ? m_cnt + 1 : 0;
`endif
        end
        #1;
    endtask

    task automatic drive(input logic ir, input logic [ADDR_W-1:0] ia, input logic fl,
                         input logic dr, input logic we, input logic [ADDR_W-1:0] da,
                         input logic [WORD_W-1:0] wd);
        if_req_i = ir; if_addr_i = ia; if_flush_i = fl;
        d_req_i = dr; d_we_i = we; d_addr_i = da; d_wdata_i = wd;
        cycle();
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 32'(i) + 32'h100;
            ref_mem[i] = 32'(i) + 32'h100;
        end
        mem[16'h8000]     = 32'hDEADBEEF;
        ref_mem[16'h8000] = 32'hDEADBEEF;

        // Reset state, including requests presented while rst is low.
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0002, 32'hAAAA5555);
        idle();
        rst = 1'b1;

        // Fetch only, four consecutive addresses.
        for (int i = 0; i < 4; i++) drive(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, '0, '0);
        idle();
        idle();

        // Collision: data wins, IF retries next cycle.
        drive(1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h8000, '0);
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, '0, '0);
        idle();
        idle();

        // Store then load of the same address.
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 16'h8004, 32'h12345678);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 16'h8004, '0);
        idle();
        idle();

        // Store and fetch to the same address in one cycle.
        drive(1'b1, 16'h0040, 1'b0, 1'b1, 1'b1, 16'h0040, 32'hCAFEF00D);
        drive(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, '0, '0);
        idle();

        // Flush squashes the returning fetch only.
        drive(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 16'h0021, 1'b1, 1'b0, 1'b0, '0, '0);
        idle();
        idle();

        // Data requesting every cycle while IF waits.
        for (int i = 0; i < 7; i++) drive(1'b1, 16'h0030, 1'b0, 1'b1, 1'b0, 16'h9000, '0);
        idle();
        idle();

        // Reset arrives at the edge ending a granted load.
        rst_at_edge = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 16'h8000, '0);
        drive(1'b1, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0006, 32'h0BADF00D);
        drive(1'b1, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0006, 32'h0BADF00D);
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 16'h8000, '0);
        idle();
        idle();

        // Random traffic honouring the hold-while-stalled rule.
        for (int n = 0; n < 400; n++) begin
            logic              ir;
            logic              dr;
            logic              we;
            logic [ADDR_W-1:0] ia;
            logic [ADDR_W-1:0] da;
            logic [WORD_W-1:0] wd;
            ir = ($urandom_range(0, 99) < 60);
            ia = 16'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000);
            dr = ($urandom_range(0, 99) < 50);
            we = ($urandom_range(0, 1) == 1);
            da = 16'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000);
            wd = $urandom;
            if (m_if_held && $urandom_range(0, 4) != 0) begin
                ir = 1'b1;
                ia = if_addr_i;
            end
            if (m_d_held) begin
                dr = 1'b1; we = d_we_i; da = d_addr_i; wd = d_wdata_i;
            end
            drive(ir, ia, ($urandom_range(0, 3) == 0), dr, we, da, wd);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the Venus core. It shares one unified 32x64k instruction/data memory between the IF fetch port and the EX load/store port. It issues at most one access per cycle, stalls the losing requester with the core's existing valid/stall handshake, and routes the one-cycle-late read data back to the requester that issued it. It sits between ifetch/execute and the memory macro, and replaces the separate imem instance once the data memory lands.

## Interface
Parameters:
- ADDR_W, 16, memory address width (equals `ADDR).
- WORD_W, 32, data width (equals `WORD).
- STARVE_MAX, 4, consecutive IF denials before IF is forced to win (used only with the starvation guard).

Ports:
- clk  in  1  core clock; one clock domain.
- rst  in  1  reset, synchronous, active-low.
- if_req_i  in  1  IF fetch request.
- if_addr_i  in  ADDR_W  fetch address.
- if_flush_i  in  1  squash the IF response in flight (branch taken).
- if_stall_o  out  1  IF request not accepted this cycle.
- if_v_o  out  1  fetch data valid.
- if_data_o  out  WORD_W  fetched instruction.
- d_req_i  in  1  data request.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  WORD_W  store data.
- d_stall_o  out  1  data request not accepted this cycle.
- d_v_o  out  1  data access complete (load data valid, or store acknowledge).
- d_rdata_o  out  WORD_W  load data.
- mem_a_o  out  ADDR_W  memory address.
- mem_w_o  out  1  memory write enable.
- mem_d_o  out  WORD_W  memory write data.
- mem_q_i  in  WORD_W  memory read data, registered inside the macro (valid the cycle after the address).

## Operation
- Grant is decided combinationally each cycle from the requests, with data having priority: EX holds the older instruction, so serving it first prevents deadlock.
- Granted requester: mem_a_o, mem_w_o and mem_d_o are driven from that port in the same cycle.
  - mem_w_o = d_we_i only when data is granted; otherwise 0.
- Stall rule: stall_o = req_i and not granted. A stalled requester holds req, addr, we and wdata stable until stall_o is low. A requester may drop an un-granted request without penalty, e.g. IF on a branch.
- Idle cycle: mem_a_o keeps its last value and mem_w_o = 0.
- Response tracking: register resp_q ∈ {NONE, IF, DATA}, loaded at each clock edge with the port granted that cycle (NONE if no grant).
- Response cycle:
  - resp_q = IF: if_v_o = 1 unless if_flush_i is high that cycle, in which case if_v_o = 0.
  - resp_q = DATA: d_v_o = 1, for both loads and stores.
- if_data_o and d_rdata_o are both driven directly from mem_q_i. They are meaningful only while the corresponding v_o is high.
- if_flush_i asserted while an IF request is pending has no effect on that request. It affects only the response returning in the same cycle.
- Reset (rst low at an edge):
  - resp_q = NONE and starve counter = 0.
  - While rst is low: if_stall_o = d_stall_o = 1, if_v_o = d_v_o = 0, mem_w_o = 0.
  - An access granted in the cycle before reset produces no response after reset.

## Timing
- Accepted access: address issued in cycle N; v_o and data valid in cycle N+1. Throughput is one access per cycle in total.
- Both ports requesting in cycle N: data is granted in N and IF is stalled. IF is granted in N+1 unless data requests again.
- Back-to-back data requests stall IF indefinitely unless the starvation guard is compiled in.
- A store in N followed by a load of the same address in N+1 returns the stored value in N+2, because the macro provides write-then-read ordering.
- A store and a fetch to the same address in the same cycle: the store wins and the fetch proceeds in N+1, reading the new value.

## Configuration
- MEM_ARB_STARVE_EN defined:
  - A starve counter (width clog2(STARVE_MAX+1)) increments on every cycle in which IF is stalled.
  - It clears on any cycle where IF is granted or if_req_i is low.
  - When the counter equals STARVE_MAX and both ports request, IF is granted and data is stalled for that cycle.
- MEM_ARB_STARVE_EN undefined: strict data priority; no counter is instantiated.

## Structure
- Shared params header/package holds:
  - RESP_NONE, RESP_IF, RESP_DATA encodings (2 bits) and the W_RESP width;
  - the default value of STARVE_MAX.
- One sub-module, mem_arb_prio: the combinational grant picker, with the starve counter under the macro. The top level holds resp_q, the port muxing and the response routing.

## Test plan
- Fetch only: IF requests addresses 0x0000–0x0003 in consecutive cycles with memory preloaded to addr+0x100 -> if_stall_o = 0 throughout; if_v_o high on 4 consecutive cycles, one cycle after each request, with data 0x100–0x103.
- Collision: in the same cycle, IF requests 0x0010 and EX loads 0x8000 (contents 0xDEADBEEF) -> d_stall_o = 0, if_stall_o = 1; next cycle d_v_o = 1 with 0xDEADBEEF and IF is granted; if_v_o follows one cycle later.
- Store-then-load: store 0x12345678 to 0x8004, then load 0x8004 in the next cycle -> mem_w_o = 1 for exactly one cycle; the load returns 0x12345678 with d_v_o high two cycles after the store.
- Flush: IF granted at 0x0020, and if_flush_i = 1 in the following cycle -> if_v_o = 0 in that cycle; the next un-flushed fetch returns normally.
- Starvation (MEM_ARB_STARVE_EN, STARVE_MAX = 4): data requests every cycle while IF requests continuously -> IF stalled for 4 cycles, granted on the 5th cycle with d_stall_o = 1 in that cycle. Without the macro, IF stays stalled for the whole burst.
- Reset mid-access: load granted in cycle N, rst low at the edge ending N -> d_v_o = 0 after the reset edge; while rst is low both stall outputs = 1 and mem_w_o = 0; normal operation resumes on the first cycle after rst returns high.
